// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines x 4 bytes.
// Hits are served combinationally in IDLE; misses walk WRITEBACK/FETCH/UPDATE.
module data_cache (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  localparam int unsigned LINES   = 8;
  localparam int unsigned TAG_W   = 3;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned OFF_W   = 2;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned BLOCK_W = 32;
  localparam int unsigned SEL_W   = OFF_W + 3;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

  state_t             state;
  logic [BLOCK_W-1:0] data_q [LINES];
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [BLOCK_W-1:0] fill_q;
  logic [BYTE_W-1:0]  readdata_q;
  logic [TAG_W-1:0]   miss_tag_q;
  logic [IDX_W-1:0]   miss_idx_q;

  logic [TAG_W-1:0]   tag_in;
  logic [IDX_W-1:0]   idx_in;
  logic [OFF_W-1:0]   off_in;
  logic [SEL_W-1:0]   bit_sel;
  logic [IDX_W-1:0]   cur_idx;
  logic [TAG_W-1:0]   cur_tag;
  logic [BYTE_W-1:0]  sel_byte;
  logic               req;
  logic               hit;

  assign tag_in  = ADDRESS[7:5];
  assign idx_in  = ADDRESS[4:2];
  assign off_in  = ADDRESS[1:0];
  assign bit_sel = {off_in, 3'b000};
  assign req     = READ | WRITE;

  // The miss address is latched so a dropped request cannot corrupt the fill.
  assign cur_idx = (state == IDLE) ? idx_in : miss_idx_q;
  assign cur_tag = (state == IDLE) ? tag_in : miss_tag_q;

  assign hit      = valid_q[idx_in] && (tag_q[idx_in] == tag_in);
  assign sel_byte = data_q[idx_in][bit_sel +: BYTE_W];

  // CPU-side outputs: zero-stall hit path, last byte held otherwise.
  always_comb begin
    BUSYWAIT = (state != IDLE) || (req && !hit);
    READDATA = readdata_q;
    if ((state == IDLE) && READ && !WRITE && hit) READDATA = sel_byte;
  end

  // Memory-side outputs decoded from the state register.
  always_comb begin
    MEM_READ      = (state == FETCH);
    MEM_WRITE     = (state == WRITEBACK);
    MEM_ADDRESS   = {cur_tag, cur_idx};
    MEM_WRITEDATA = data_q[cur_idx];
    if (state == WRITEBACK) MEM_ADDRESS = {tag_q[cur_idx], cur_idx};
  end

  // Controller FSM and line storage updates.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state      <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      readdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (WRITE) begin
                data_q[idx_in][bit_sel +: BYTE_W] <= WRITEDATA;
                dirty_q[idx_in]                   <= 1'b1;
              end else begin
                readdata_q <= sel_byte;
              end
            end else begin
              miss_tag_q <= tag_in;
              miss_idx_q <= idx_in;
              if (valid_q[idx_in] && dirty_q[idx_in]) state <= WRITEBACK;
              else                                    state <= FETCH;
            end
          end
        end
        WRITEBACK: begin
          if (!MEM_BUSYWAIT) state <= FETCH;
        end
        FETCH: begin
          if (!MEM_BUSYWAIT) begin
            fill_q <= MEM_READDATA;
            state  <= UPDATE;
          end
        end
        UPDATE: begin
          data_q[miss_idx_q]  <= fill_q;
          tag_q[miss_idx_q]   <= miss_tag_q;
          valid_q[miss_idx_q] <= 1'b1;
          dirty_q[miss_idx_q] <= 1'b0;
          state               <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache with a fixed-latency block memory model.
module tb_data_cache;

  localparam int LAT = 5;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  data_cache dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } mem_exp_t;

  logic [7:0] rd_q [$];
  mem_exp_t   mem_q [$];
  int         checks = 0;
  int         errors = 0;

  // Memory model: busy for LAT cycles from the request cycle, then one ready cycle.
  logic [31:0] mem [64];
  int          mem_cnt;
  logic        mem_init;
  logic        mem_req;

  assign mem_req      = MEM_READ | MEM_WRITE;
  assign MEM_BUSYWAIT = mem_req && (mem_cnt != LAT);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[6'h09] <= 32'hDDCCBBAA;
      mem[6'h11] <= 32'h44332211;
      mem[6'h19] <= 32'h87654321;
      mem[6'h21] <= 32'hCAFEF00D;
      mem_cnt    <= 0;
    end else if (!mem_req) begin
      mem_cnt <= 0;
    end else if (mem_cnt == LAT) begin
      mem_cnt <= 0;
      if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
    end else begin
      mem_cnt <= mem_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_mem(input logic wr, input logic [5:0] addr, input logic [31:0] data);
    mem_exp_t e;
    e.wr   = wr;
    e.addr = addr;
    e.data = data;
    mem_q.push_back(e);
  endtask

  // Monitor: compares completed loads and new memory requests against the queues.
  always @(negedge CLK) begin
    if (RESET === 1'b1 && !mem_init) begin
      if (MEM_READ && MEM_WRITE) check("mem_exclusive", 32'(MEM_READ & MEM_WRITE), 32'h0);
      if (READ && !WRITE && !BUSYWAIT) begin
        if (rd_q.size() == 0) check("readdata_unexpected", 32'h1, 32'h0);
        else                  check("readdata", 32'(READDATA), 32'(rd_q.pop_front()));
      end
      if (mem_req && mem_cnt == 0) begin
        if (mem_q.size() == 0) begin
          check("mem_req_unexpected", 32'(MEM_ADDRESS), 32'hFFFF_FFFF);
        end else begin
          mem_exp_t e;
          e = mem_q.pop_front();
          check("mem_kind_write", 32'(MEM_WRITE), 32'(e.wr));
          check("mem_address", 32'(MEM_ADDRESS), 32'(e.addr));
          if (e.wr) check("mem_writedata", MEM_WRITEDATA, e.data);
        end
      end
    end
  end

  // One CPU access held until BUSYWAIT drops; checks the stall cycle count.
  task automatic cpu_access(input logic rd, input logic wr, input logic [7:0] addr,
                            input logic [7:0] wdata, input logic [7:0] rdexp,
                            input int exp_stall);
    int stall = 0;
    bit ok = 1'b0;
    @(posedge CLK); #1;
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wdata;
    if (rd && !wr) rd_q.push_back(rdexp);
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (!BUSYWAIT) begin
        ok = 1'b1;
        break;
      end
      stall++;
    end
    if (!ok) check("busywait_timeout", 32'h1, 32'h0);
    else     check($sformatf("stall_addr_%0h", addr), 32'(stall), 32'(exp_stall));
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bit ok;
    RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h0; WRITEDATA = 8'h0;
    mem_init = 1'b1;
    repeat (2) @(posedge CLK);
    #1 mem_init = 1'b0;
    @(negedge CLK);
    check("reset_busywait", 32'(BUSYWAIT), 32'h0);
    check("reset_mem_read", 32'(MEM_READ), 32'h0);
    check("reset_mem_write", 32'(MEM_WRITE), 32'h0);
    check("reset_readdata", 32'(READDATA), 32'h0);
    @(posedge CLK); #1 RESET = 1'b1;

    // Cold clean miss: 1 IDLE + (LAT+1) FETCH + 1 UPDATE stall cycles.
    exp_mem(1'b0, 6'h09, 32'h0);
    cpu_access(1'b1, 1'b0, 8'h25, 8'h00, 8'hBB, 8);

    // Write hit then read-back, no stall.
    cpu_access(1'b0, 1'b1, 8'h26, 8'h5A, 8'h00, 0);
    cpu_access(1'b1, 1'b0, 8'h26, 8'h00, 8'h5A, 0);

    // Conflict on dirty line 1: writeback then fetch.
    exp_mem(1'b1, 6'h09, 32'hDD5ABBAA);
    exp_mem(1'b0, 6'h11, 32'h0);
    cpu_access(1'b1, 1'b0, 8'h45, 8'h00, 8'h22, 14);
    check("wb_memory_content", mem[6'h09], 32'hDD5ABBAA);

    // Bring tag 1 back (clean victim), then READ=WRITE=1 hit writes byte 0.
    exp_mem(1'b0, 6'h09, 32'h0);
    cpu_access(1'b1, 1'b0, 8'h24, 8'h00, 8'hAA, 8);
    cpu_access(1'b1, 1'b1, 8'h24, 8'h77, 8'h00, 0);
    cpu_access(1'b1, 1'b0, 8'h24, 8'h00, 8'h77, 0);
    // Dirty line proven by the writeback it forces.
    exp_mem(1'b1, 6'h09, 32'hDD5ABB77);
    exp_mem(1'b0, 6'h11, 32'h0);
    cpu_access(1'b1, 1'b0, 8'h44, 8'h00, 8'h11, 14);

    // Reset in the second FETCH cycle abandons the fill.
    exp_mem(1'b0, 6'h19, 32'h0);
    @(posedge CLK); #1 READ = 1'b1; ADDRESS = 8'h65;
    @(posedge CLK); #1;
    @(posedge CLK); #1 RESET = 1'b0;
    @(posedge CLK); #1 RESET = 1'b1; READ = 1'b0;
    @(negedge CLK);
    check("post_reset_mem_read", 32'(MEM_READ), 32'h0);
    check("post_reset_busywait", 32'(BUSYWAIT), 32'h0);
    exp_mem(1'b0, 6'h19, 32'h0);
    cpu_access(1'b1, 1'b0, 8'h65, 8'h00, 8'h43, 8);

    // Request dropped mid-FETCH: the fill still lands.
    exp_mem(1'b0, 6'h21, 32'h0);
    @(posedge CLK); #1 READ = 1'b1; ADDRESS = 8'h85;
    @(posedge CLK); #1;
    @(posedge CLK); #1 READ = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (!BUSYWAIT) begin
        ok = 1'b1;
        break;
      end
    end
    check("drop_returns_idle", 32'(ok), 32'h1);
    repeat (2) @(posedge CLK);
    cpu_access(1'b1, 1'b0, 8'h85, 8'h00, 8'hF0, 0);

    repeat (3) @(posedge CLK);
    check("readdata_queue_empty", 32'(rd_q.size()), 32'h0);
    check("mem_queue_empty", 32'(mem_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- CLK, input, 1: single clock, all state changes on posedge.
- RESET, input, 1: synchronous, active-low reset; it is sampled at posedge CLK only.
- READ, input, 1: CPU load request.
- WRITE, input, 1: CPU store request.
- ADDRESS, input, 8: CPU byte address, split as tag[7:5], index[4:2], offset[1:0].
- WRITEDATA, input, 8: CPU store data.
- READDATA, output, 8: CPU load data.
- BUSYWAIT, output, 1: CPU stall.
- MEM_READ, output, 1: main memory block read request.
- MEM_WRITE, output, 1: main memory block write request.
- MEM_ADDRESS, output, 6: block address {tag, index}.
- MEM_WRITEDATA, output, 32: block being written back.
- MEM_READDATA, input, 32: block returned by memory.
- MEM_BUSYWAIT, input, 1: memory busy; memory holds it high from the request cycle until the transfer completes.
REQ-002 There SHALL be a single clock domain (CLK) with no parameters; geometry is fixed at 8 blocks x 4 bytes, direct-mapped, write-back, write-allocate.

Function
REQ-003 Per line storage SHALL be: valid bit, dirty bit, 3-bit tag and 32-bit data, with byte n at bits [8n+7:8n].
REQ-004 A hit SHALL be defined as valid[index] && tag[index]==ADDRESS[7:5], evaluated combinationally.
REQ-005 The FSM SHALL have the states IDLE, WRITEBACK, FETCH and UPDATE.
REQ-006 In IDLE with (READ|WRITE) and a hit, BUSYWAIT SHALL be 0, with these effects:
- A read SHALL drive READDATA with the selected byte in the same cycle.
- A write SHALL update the selected byte and set dirty at the next posedge.
REQ-007 In IDLE with (READ|WRITE) and a miss, BUSYWAIT SHALL be 1 combinationally in that cycle, and the next state SHALL be:
- WRITEBACK when the line is valid and dirty;
- FETCH otherwise.
REQ-008 In WRITEBACK, the block SHALL drive:
- MEM_WRITE=1;
- MEM_ADDRESS={stored tag, index};
- MEM_WRITEDATA=line data.
On the first posedge with MEM_BUSYWAIT=0 it SHALL go to FETCH.
REQ-009 In FETCH, the block SHALL drive MEM_READ=1 and MEM_ADDRESS={ADDRESS[7:5], index}. On the first posedge with MEM_BUSYWAIT=0 it SHALL go to UPDATE.
REQ-010 The UPDATE state SHALL behave as follows:
- It SHALL last exactly one cycle.
- It SHALL latch MEM_READDATA, as sampled on the FETCH-exit edge, into the line, with valid=1, dirty=0 and tag=ADDRESS[7:5].
- It SHALL then return to IDLE.
- In IDLE the request re-evaluates as a hit per REQ-006.
REQ-011 BUSYWAIT SHALL be 1 in WRITEBACK, FETCH and UPDATE.
REQ-012 MEM_READ and MEM_WRITE SHALL be 0 in every state not named in REQ-008 and REQ-009, and SHALL never be 1 together.
REQ-013 When READ and WRITE are both 1, WRITE SHALL take priority.
REQ-014 ADDRESS, READ, WRITE and WRITEDATA SHALL be held stable by the CPU while BUSYWAIT=1. If the request drops mid-miss, the fill SHALL still complete and the FSM SHALL then return to IDLE.
REQ-015 With no request, BUSYWAIT SHALL be 0 and READDATA SHALL hold the last selected byte value. Its value is don't-care for checking.
REQ-016 Miss latency SHALL be:
- clean: memory cycles + 1 (UPDATE) + 1 (hit cycle);
- dirty: writeback cycles + the clean latency.

Reset
REQ-017 On a posedge with RESET=0, the block SHALL:
- clear all valid and dirty bits;
- set state to IDLE;
- drive MEM_READ=0, MEM_WRITE=0, BUSYWAIT=0, READDATA=0 from the following cycle.
REQ-018 A reset during WRITEBACK or FETCH SHALL abandon the transfer without writing the line. The memory request SHALL be dropped in the cycle after the reset edge.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Cold read 0x25, memory returns 0xDDCCBBAA after 5 cycles busy -> MEM_READ=1 with MEM_ADDRESS=0x09, then one UPDATE cycle, then READDATA=0xBB with BUSYWAIT=0.
- Write 0x26 data 0x5A after that fill -> hit with no stall; a following read of 0x26 returns 0x5A, and line 1 is dirty.
- Read 0x45 (same index, tag 2) -> WRITEBACK with MEM_ADDRESS=0x09 and MEM_WRITEDATA=0xDD5ABBAA, then FETCH with MEM_ADDRESS=0x11, then a hit.
- READ=WRITE=1 on a hit line, address 0x24, data 0x77 -> byte 0 becomes 0x77 and dirty=1.
- RESET=0 asserted in cycle 2 of FETCH -> next cycle MEM_READ=0 and BUSYWAIT=0; a re-read of the same address misses.
- CPU drops READ mid-FETCH -> UPDATE still occurs, then IDLE; a later read of that address is a zero-stall hit.
